hazard_ctrl: RTL

- Central stall/flush/forward controller for the 5-stage MIPS pipeline.
- Drives the StallX/FlushX inputs of every stage register (F, D, E, M, W) and the forwarding muxes in D and E.
- Owns a sequential multiply/divide occupancy FSM that holds E for a fixed latency, plus arbitration of I-side and D-side memory waits.
- Sits beside the datapath and consumes the register indices and control bits the stage registers carry.

---
 rtl/hazard_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Purpose
//   Central stall / flush / forward controller for a 5-stage MIPS pipeline
//   (F, D, E, M, W). It produces the hold (StallX) and bubble (FlushX) controls
//   for every stage register and the operand-forwarding selects for the D-stage
//   branch comparator and the E-stage ALU.
//
//   It also owns the sequential multiply/divide occupancy FSM, which holds E
//   for MULDIV_LAT cycles. It arbitrates instruction-side and data-side memory
//   wait requests against the other hazards.
//
// Parameters
//   MULDIV_LAT  cycles a mult/div occupies E (>= 2)
//
// Optional build macro
//   HAZARD_PERF_EN  when defined, PerfStallCnt counts the cycles with
//                   StallF == 1. When undefined, no counter is built and
//                   PerfStallCnt is tied to zero.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   RsD, RtD, UseRsD, UseRtD    D-stage source regs and whether they are read
//   BranchD                     D holds a branch/jr resolved in D
//   RsE, RtE                    E-stage source regs
//   WriteReg{E,M,W}             destination regs of E, M, W
//   RegWrite{E,M,W}             stage writes the register file
//   MemtoReg{E,M}               stage holds a load
//   MulDivStartE                E holds a mult/div
//   ImemBusy, DmemBusy          memory wait requests
//   Stall{F,D,E,M}              hold stage register
//   Flush{D,E,M,W}              insert bubble into stage register
//   ForwardAD/BD                select ALUOutM for the D comparator operands
//   ForwardAE/BE                00 regfile, 10 from M, 01 from W
//   MulDivBusy                  mult/div FSM not idle
//   MulDivDone                  one-cycle pulse, mult/div result ready
//   PerfStallCnt                fetch-stall cycle counter (optional)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MULDIV_LAT = 32
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic        UseRsD,
  input  logic        UseRtD,
  input  logic        BranchD,

  input  logic [4:0]  RsE,
  input  logic [4:0]  RtE,

  input  logic [4:0]  WriteRegE,
  input  logic [4:0]  WriteRegM,
  input  logic [4:0]  WriteRegW,
  input  logic        RegWriteE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemtoRegE,
  input  logic        MemtoRegM,

  input  logic        MulDivStartE,
  input  logic        ImemBusy,
  input  logic        DmemBusy,

  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushM,
  output logic        FlushW,

  output logic        ForwardAD,
  output logic        ForwardBD,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,

  output logic        MulDivBusy,
  output logic        MulDivDone,
  output logic [31:0] PerfStallCnt
);

  // ---------------------------------------------------------------------------
  // Mult/div counter sizing. The counter is loaded with MULDIV_LAT-2, because
  // the IDLE cycle that accepts the instruction and the final BUSY cycle with
  // cnt == 0 together account for the remaining two cycles in E.
  // ---------------------------------------------------------------------------
  localparam int CW = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MULDIV_LAT - 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  md_state_e       state_q;
  md_state_e       state_d;
  md_state_e       state_eff;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;

  // While reset is high the FSM is treated as IDLE, so every combinational
  // output already reflects the post-reset state.
  assign state_eff = reset ? ST_IDLE : state_q;

  // ---------------------------------------------------------------------------
  // Producer qualifiers. Register 0 is hard-wired to zero and never counts as
  // a dependency.
  // ---------------------------------------------------------------------------
  logic we_nz;
  logic wm_nz;
  logic ww_nz;

  assign we_nz = (WriteRegE != 5'd0);
  assign wm_nz = (WriteRegM != 5'd0);
  assign ww_nz = (WriteRegW != 5'd0);

  // ---------------------------------------------------------------------------
  // E-stage forwarding. Index 0 handles Rs (A operand) and index 1 handles
  // Rt (B operand). M is newer than W, so M takes priority over W.
  // ---------------------------------------------------------------------------
  logic [4:0] src_e [2];
  logic [1:0] fwd_e [2];

  assign src_e[0] = RsE;
  assign src_e[1] = RtE;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd_e
      logic m_hit;
      logic w_hit;

      assign m_hit = RegWriteM && wm_nz && (WriteRegM == src_e[gi]);
      assign w_hit = RegWriteW && ww_nz && (WriteRegW == src_e[gi]);
      assign fwd_e[gi] = m_hit ? 2'b10 : (w_hit ? 2'b01 : 2'b00);
    end
  endgenerate

  assign ForwardAE = fwd_e[0];
  assign ForwardBE = fwd_e[1];

  // ---------------------------------------------------------------------------
  // D-stage dependencies. The branch comparator sits in D, so only ALUOutM can
  // be forwarded there. Anything still in E, or a load still in M, must stall
  // the branch instead.
  // ---------------------------------------------------------------------------
  logic [4:0] src_d [2];
  logic [1:0] use_d;
  logic [1:0] fwd_d;
  logic [1:0] e_dep;
  logic [1:0] m_dep;

  assign src_d[0] = RsD;
  assign src_d[1] = RtD;
  assign use_d    = {UseRtD, UseRsD};

  generate
    for (gi = 0; gi < 2; gi++) begin : g_dep_d
      assign fwd_d[gi] = RegWriteM && wm_nz && (WriteRegM == src_d[gi]);
      assign e_dep[gi] = use_d[gi] && (WriteRegE == src_d[gi]);
      assign m_dep[gi] = use_d[gi] && (WriteRegM == src_d[gi]);
    end
  endgenerate

  assign ForwardAD = fwd_d[0];
  assign ForwardBD = fwd_d[1];

  // ---------------------------------------------------------------------------
  // Hazard terms
  // ---------------------------------------------------------------------------
  logic lwstall;
  logic brstall;
  logic mdstall;

  assign lwstall = MemtoRegE && RegWriteE && we_nz && (|e_dep);

  assign brstall = BranchD &&
                   ((RegWriteE && we_nz && (|e_dep)) ||
                    (MemtoRegM && wm_nz && (|m_dep)));

  // In DONE the instruction may still sit in E (held by a memory wait), but
  // it no longer requests a stall of its own.
  assign mdstall = ((state_eff == ST_IDLE) && MulDivStartE) ||
                   ((state_eff == ST_BUSY) && (cnt_q != '0));

  // ---------------------------------------------------------------------------
  // Stall/flush priority. Exactly one row drives the stage controls.
  //   DmemBusy : freeze F..M, and W takes a bubble because M cannot retire
  //   mdstall  : freeze F..E, and M takes a bubble
  //   lw/br    : freeze F, D, and E takes a bubble
  //   ImemBusy : freeze F, and D takes a bubble
  // ---------------------------------------------------------------------------
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    FlushW = 1'b0;

    if (DmemBusy) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (mdstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (lwstall || brstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else if (ImemBusy) begin
      StallF = 1'b1;
      FlushD = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Mult/div occupancy FSM: next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_eff;
    cnt_d      = cnt_q;
    MulDivDone = 1'b0;

    unique case (state_eff)
      ST_IDLE: begin
        if (MulDivStartE) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_INIT;
        end
      end

      ST_BUSY: begin
        if (cnt_q != '0) begin
          // A data-memory wait freezes the whole back end, including the
          // mult/div unit, so the count holds.
          if (!DmemBusy) begin
            cnt_d = cnt_q - CW'(1);
          end
        end else begin
          MulDivDone = 1'b1;
          // If E cannot advance (memory wait), park in DONE so that the
          // still-present MulDivStartE is not mistaken for a new instruction.
          state_d = StallE ? ST_DONE : ST_IDLE;
        end
      end

      ST_DONE: begin
        if (!StallE) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign MulDivBusy = (state_eff != ST_IDLE);

  // ---------------------------------------------------------------------------
  // Optional fetch-stall performance counter
  // ---------------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_q;
  logic [31:0] perf_d;

  // Wraps naturally from 0xFFFFFFFF to 0.
  assign perf_d = StallF ? (perf_q + 32'd1) : perf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= 32'd0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign PerfStallCnt = perf_q;
`else
  assign PerfStallCnt = 32'd0;
`endif

endmodule
